// File: rtl/register_file_multiport_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rv32i_regfile_pkg                                                    |
// | Shared types and ABI register indices for the rv32i register file.  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package rv32i_regfile_pkg;

  typedef enum logic [0:0] {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } regfile_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd1;
  localparam logic [4:0] REG_SP   = 5'd2;
  localparam logic [4:0] REG_GP   = 5'd3;
  localparam logic [4:0] REG_TP   = 5'd4;
  localparam logic [4:0] REG_T0   = 5'd5;
  localparam logic [4:0] REG_T1   = 5'd6;
  localparam logic [4:0] REG_T2   = 5'd7;
  localparam logic [4:0] REG_S0   = 5'd8;
  localparam logic [4:0] REG_S1   = 5'd9;
  localparam logic [4:0] REG_A0   = 5'd10;
  localparam logic [4:0] REG_A1   = 5'd11;
  localparam logic [4:0] REG_A2   = 5'd12;
  localparam logic [4:0] REG_A3   = 5'd13;
  localparam logic [4:0] REG_A4   = 5'd14;
  localparam logic [4:0] REG_A5   = 5'd15;
  localparam logic [4:0] REG_A6   = 5'd16;
  localparam logic [4:0] REG_A7   = 5'd17;
  localparam logic [4:0] REG_S2   = 5'd18;
  localparam logic [4:0] REG_S3   = 5'd19;
  localparam logic [4:0] REG_S4   = 5'd20;
  localparam logic [4:0] REG_S5   = 5'd21;
  localparam logic [4:0] REG_S6   = 5'd22;
  localparam logic [4:0] REG_S7   = 5'd23;
  localparam logic [4:0] REG_S8   = 5'd24;
  localparam logic [4:0] REG_S9   = 5'd25;
  localparam logic [4:0] REG_S10  = 5'd26;
  localparam logic [4:0] REG_S11  = 5'd27;
  localparam logic [4:0] REG_T3   = 5'd28;
  localparam logic [4:0] REG_T4   = 5'd29;
  localparam logic [4:0] REG_T5   = 5'd30;
  localparam logic [4:0] REG_T6   = 5'd31;

endpackage
`default_nettype wire

// File: rtl/register_file_multiport_clear_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_clear_fsm                                                    |
// | Post-reset clear sweep sequencer and dropped-write flag.            |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module regfile_clear_fsm
  import rv32i_regfile_pkg::*;
#(
  parameter  int NREGS = 32,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_ena,
  output logic          busy,
  output logic          wr_dropped,
  output logic          clr_ena,
  output logic [AW-1:0] clr_addr
);

  localparam logic [0:0] ST_CLEAR = RF_CLEAR;
  localparam logic [0:0] ST_READY = RF_READY;

  logic [0:0]    r_state;
  logic [AW-1:0] r_ptr;
  logic          r_dropped;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_CLEAR;
      r_ptr     <= '0;
      r_dropped <= 1'b0;
    end else begin
      r_dropped <= (r_state == ST_CLEAR) && wr_ena;
      if (r_state == ST_CLEAR) begin
        r_ptr <= r_ptr + 1'b1;
        if (r_ptr == AW'(NREGS - 1)) begin
          r_state <= ST_READY;
        end
      end
    end
  end

  assign busy       = (r_state == ST_CLEAR);
  assign wr_dropped = r_dropped;
  // Reset itself must not touch storage, so the sweep writes only once rst drops.
  assign clr_ena    = busy && !rst;
  assign clr_addr   = r_ptr;

endmodule
`default_nettype wire

// File: rtl/register_file_multiport.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | register_file_multiport                                              |
// | Flop-based register file, NREAD comb read ports, one write port.    |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module register_file_multiport
  import rv32i_regfile_pkg::*;
#(
  parameter  int WIDTH    = 32,
  parameter  int NREGS    = 32,
  parameter  int NREAD    = 2,
  parameter  int ZERO_REG = 1,
  parameter  int BYPASS   = 1,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_ena,
  input  logic [AW-1:0]          wr_addr,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic [NREAD*AW-1:0]    rd_addr,
  output logic [NREAD*WIDTH-1:0] rd_data,
  output logic                   busy,
  output logic                   wr_dropped
);

  logic             w_busy;
  logic             w_clr_ena;
  logic [AW-1:0]    w_clr_addr;
  logic             w_wr_req;
  logic [WIDTH-1:0] w_din;
  logic [NREGS-1:0] w_reg_en;
  logic [WIDTH-1:0] w_regs [NREGS];

  regfile_clear_fsm #(
    .NREGS (NREGS)
  ) u_clear_fsm (
    .clk        (clk),
    .rst        (rst),
    .wr_ena     (wr_ena),
    .busy       (w_busy),
    .wr_dropped (wr_dropped),
    .clr_ena    (w_clr_ena),
    .clr_addr   (w_clr_addr)
  );

  assign busy     = w_busy;
  assign w_wr_req = wr_ena && !w_busy;
  // Sweep and functional writes are mutually exclusive, so one data mux suffices.
  assign w_din    = w_clr_ena ? '0 : wr_data;

  for (genvar i = 0; i < NREGS; i++) begin : g_regs
    localparam logic [AW-1:0] c_IDX    = AW'(i);
    localparam bit            c_LOCKED = (ZERO_REG != 0) && (i == 0);
    logic [WIDTH-1:0] r_q;

    assign w_reg_en[i] = (w_clr_ena && (w_clr_addr == c_IDX)) ||
                         (w_wr_req && !c_LOCKED && (wr_addr == c_IDX));

    always_ff @(posedge clk) begin
      if (w_reg_en[i]) begin
        r_q <= w_din;
      end
    end

    assign w_regs[i] = r_q;
  end

  for (genvar p = 0; p < NREAD; p++) begin : g_rd
    logic [AW-1:0]    w_addr;
    logic [WIDTH-1:0] w_rd;

    assign w_addr = rd_addr[p*AW +: AW];

    always_comb begin
      w_rd = w_regs[w_addr];
      if (w_busy) begin
        w_rd = '0;
      end else if ((ZERO_REG != 0) && (w_addr == '0)) begin
        w_rd = '0;
      end else if ((BYPASS != 0) && wr_ena && (wr_addr == w_addr)) begin
        w_rd = wr_data;
      end
    end

    assign rd_data[p*WIDTH +: WIDTH] = w_rd;
  end

endmodule
`default_nettype wire
